// File: rtl/mdp_pkg.sv
// Shared MD+ definitions: feeder FSM states and PCM buffer geometry.
package mdp_pkg;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_RSTPTR,
    FEED_WAIT_SPACE,
    FEED_FETCH,
    FEED_WRITE,
    FEED_SETTLE
  } feed_state_t;

  localparam int MDP_SECTOR_BYTES   = 2352;
  localparam int MDP_PCM_BUFF_BYTES = 8192;

endpackage

// File: rtl/mdp_pcm_feeder.sv
// Streams sector-sized blocks of PCM bytes from a byte-wide memory read port
// into the MD+ PCM ring buffer, checking for free space once per sector.
module mdp_pcm_feeder
  import mdp_pkg::*;
#(
  parameter int SECTOR_BYTES = MDP_SECTOR_BYTES,
  parameter int ADDR_W       = 24,
  parameter int SETTLE       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       sec_count,
  input  logic              loop_en,
  input  logic              can_wr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dat,
  output logic              buff_we,
  output logic [7:0]        buff_dat,
  output logic              addr_rst,
  output logic              play,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sec_left
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [11:0] LAST_BYTE = 12'(SECTOR_BYTES - 1);
  localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE - 1);

  feed_state_t         state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
  logic [15:0]         sec_left_q, sec_left_d;
  logic [15:0]         sec_total_q, sec_total_d;
  logic [11:0]         byte_cnt_q, byte_cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                primed_q, primed_d;
  logic                pend_q, pend_d;
  logic [7:0]          buff_dat_q, buff_dat_d;
  logic                mem_req_q, mem_req_d;
  logic                buff_we_q, buff_we_d;
  logic                addr_rst_q, addr_rst_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FEED_IDLE;
      cur_addr_q  <= '0;
      base_addr_q <= '0;
      sec_left_q  <= '0;
      sec_total_q <= '0;
      byte_cnt_q  <= '0;
      settle_q    <= '0;
      primed_q    <= 1'b0;
      pend_q      <= 1'b0;
      buff_dat_q  <= '0;
      mem_req_q   <= 1'b0;
      buff_we_q   <= 1'b0;
      addr_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      base_addr_q <= base_addr_d;
      sec_left_q  <= sec_left_d;
      sec_total_q <= sec_total_d;
      byte_cnt_q  <= byte_cnt_d;
      settle_q    <= settle_d;
      primed_q    <= primed_d;
      pend_q      <= pend_d;
      buff_dat_q  <= buff_dat_d;
      mem_req_q   <= mem_req_d;
      buff_we_q   <= buff_we_d;
      addr_rst_q  <= addr_rst_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are computed from the next state so that every port comes straight off a flop.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    base_addr_d = base_addr_q;
    sec_left_d  = sec_left_q;
    sec_total_d = sec_total_q;
    byte_cnt_d  = byte_cnt_q;
    settle_d    = settle_q;
    primed_d    = primed_q;
    pend_d      = pend_q;
    buff_dat_d  = buff_dat_q;
    buff_we_d   = 1'b0;
    addr_rst_d  = 1'b0;
    done_d      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      FEED_IDLE: begin
        if (stop) begin
          primed_d = 1'b0;
        end else if (start) begin
          if (sec_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            cur_addr_d  = src_addr;
            base_addr_d = src_addr;
            sec_left_d  = sec_count;
            sec_total_d = sec_count;
            byte_cnt_d  = '0;
            primed_d    = 1'b0;
            pend_d      = 1'b0;
            addr_rst_d  = 1'b1;
            state_d     = FEED_RSTPTR;
          end
        end
      end
      FEED_RSTPTR: begin
        if (stop) abort = 1'b1;
        else      state_d = FEED_WAIT_SPACE;
      end
      FEED_WAIT_SPACE: begin
        if (stop)        abort = 1'b1;
        else if (can_wr) state_d = FEED_FETCH;
      end
      // A stop here must not drop the outstanding request; it is remembered and acted on at the ack.
      FEED_FETCH: begin
        if (mem_ack) begin
          if (stop || pend_q) begin
            abort = 1'b1;
          end else begin
            buff_dat_d = mem_dat;
            buff_we_d  = 1'b1;
            state_d    = FEED_WRITE;
          end
        end else if (stop) begin
          pend_d = 1'b1;
        end
      end
      FEED_WRITE: begin
        if (stop) begin
          abort = 1'b1;
        end else begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_d = byte_cnt_q + 12'd1;
            state_d    = FEED_FETCH;
          end else begin
            byte_cnt_d = '0;
            primed_d   = 1'b1;
            settle_d   = '0;
            sec_left_d = (sec_left_q != 16'd0) ? sec_left_q - 16'd1 : 16'd0;
            if (sec_left_q <= 16'd1 && !loop_en) begin
              done_d  = 1'b1;
              state_d = FEED_IDLE;
            end else if (sec_left_q <= 16'd1) begin
              cur_addr_d = base_addr_q;
              sec_left_d = sec_total_q;
              state_d    = FEED_SETTLE;
            end else begin
              state_d = FEED_SETTLE;
            end
          end
        end
      end
      FEED_SETTLE: begin
        if (stop) begin
          abort = 1'b1;
        end else if (settle_q == LAST_SETTLE) begin
          state_d = FEED_WAIT_SPACE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: state_d = FEED_IDLE;
    endcase

    if (abort) begin
      state_d    = FEED_IDLE;
      primed_d   = 1'b0;
      pend_d     = 1'b0;
      buff_we_d  = 1'b0;
      addr_rst_d = 1'b1;
    end

    mem_req_d = (state_d == FEED_FETCH);
    busy_d    = (state_d != FEED_IDLE);
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = cur_addr_q;
  assign buff_we  = buff_we_q;
  assign buff_dat = buff_dat_q;
  assign addr_rst = addr_rst_q;
  assign play     = primed_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sec_left = sec_left_q;

endmodule

// File: tb/tb_mdp_pcm_feeder.sv
// Randomized bench for mdp_pcm_feeder: a memory responder with random ack latency
// and a queue of expected source addresses that every buffer write is scored against.
module tb_mdp_pcm_feeder;

  localparam int SB = 2352;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [23:0] src_addr;
  logic [15:0] sec_count;
  logic        loop_en;
  logic        can_wr;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_dat;
  logic        buff_we;
  logic [7:0]  buff_dat;
  logic        addr_rst;
  logic        play;
  logic        busy;
  logic        done;
  logic [15:0] sec_left;

  int checks = 0;
  int errors = 0;

  mdp_pcm_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .src_addr  (src_addr),
    .sec_count (sec_count),
    .loop_en   (loop_en),
    .can_wr    (can_wr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_dat   (mem_dat),
    .buff_we   (buff_we),
    .buff_dat  (buff_dat),
    .addr_rst  (addr_rst),
    .play      (play),
    .busy      (busy),
    .done      (done),
    .sec_left  (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address so a wrong address shows up as wrong data.
  function automatic logic [7:0] memByte(input logic [23:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [23:0] expQ[$];
  int maxLat = 0;
  int fixedLat = -1;
  int curLat = 0;
  int waitCnt = 0;

  // Memory responder: drives ack/data just after each rising edge.
  initial begin
    mem_ack = 1'b0;
    mem_dat = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !mem_ack) begin
        if (waitCnt >= curLat) begin
          mem_ack = 1'b1;
          mem_dat = memByte(mem_addr);
          waitCnt = 0;
          curLat  = (fixedLat >= 0) ? fixedLat : int'($urandom_range(maxLat, 0));
        end else begin
          mem_ack = 1'b0;
          mem_dat = 8'($urandom);
          waitCnt++;
        end
      end else begin
        if (!mem_req) waitCnt = 0;
        mem_ack = 1'b0;
        mem_dat = 8'($urandom);
      end
    end
  end

  int writeCnt = 0;
  int doneCnt = 0;
  int addrRstCnt = 0;
  int reqCnt = 0;
  int playRiseAt = -1;
  bit busySeen = 0;
  logic prevWe = 0, prevReq = 0, prevAck = 0, prevPlay = 0;

  // Scoreboard and protocol monitor, sampling mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (prevWe) checkOutput("weSpacing", buff_we, 0);
      if (prevReq && !prevAck && !rst) checkOutput("reqHeld", mem_req, 1);
      if (buff_we) begin
        writeCnt++;
        checkOutput("wrExpected", expQ.size() != 0, 1);
        if (expQ.size() != 0) checkOutput("wrData", buff_dat, memByte(expQ.pop_front()));
      end
      if (done) doneCnt++;
      if (addr_rst) addrRstCnt++;
      if (mem_req) reqCnt++;
      if (busy) busySeen = 1;
      if (play && !prevPlay) playRiseAt = writeCnt;
      prevWe = buff_we;
      prevReq = mem_req;
      prevAck = mem_ack;
      prevPlay = play;
    end
  end

  task automatic buildExp(input logic [23:0] src, input int n, input int passes);
    logic [23:0] a;
    expQ.delete();
    for (int p = 0; p < passes; p++) begin
      a = src;
      for (int i = 0; i < n * SB; i++) begin
        expQ.push_back(a);
        a = a + 24'd1;
      end
    end
  endtask

  // Pulses start (caller sits on a falling edge) and checks the pointer-reset / first-request timing.
  task automatic applyStimulus(input logic [23:0] src, input logic [15:0] n, input logic lp);
    writeCnt = 0;
    playRiseAt = -1;
    src_addr = src;
    sec_count = n;
    loop_en = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("addrRstAfterStart", addr_rst, 1);
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("playCleared", play, 0);
    checkOutput("secLeftLatched", sec_left, n);
    @(negedge clk);
    checkOutput("addrRstOneCycle", addr_rst, 0);
    checkOutput("noEarlyReq", mem_req, 0);
    @(negedge clk);
    checkOutput("firstReq", mem_req, 1);
    checkOutput("firstAddr", mem_addr, src);
  endtask

  task automatic waitDone(input int budget);
    int base;
    int n;
    base = doneCnt;
    n = 0;
    while (doneCnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("doneOnce", doneCnt - base, 1);
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n;
    n = 0;
    while (writeCnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("writesReached", writeCnt >= target, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_memReq"}, mem_req, 0);
    checkOutput({tag, "_memAddr"}, mem_addr, 0);
    checkOutput({tag, "_buffWe"}, buff_we, 0);
    checkOutput({tag, "_buffDat"}, buff_dat, 0);
    checkOutput({tag, "_addrRst"}, addr_rst, 1);
    checkOutput({tag, "_play"}, play, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_secLeft"}, sec_left, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    logic [23:0] src;

    rst = 1'b1; start = 1'b0; stop = 1'b0; src_addr = '0; sec_count = '0;
    loop_en = 1'b0; can_wr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("addrRstAfterReset", addr_rst, 0);

    $display("[TB] two sectors from 0x1000, zero-wait memory");
    maxLat = 0; fixedLat = -1; curLat = 0;
    buildExp(24'h001000, 2, 1);
    applyStimulus(24'h001000, 16'd2, 1'b0);
    waitDone(12000);
    checkOutput("t1Writes", writeCnt, 2 * SB);
    checkOutput("t1QueueEmpty", expQ.size(), 0);
    checkOutput("t1PlayRise", playRiseAt, SB);
    checkOutput("t1SecLeft", sec_left, 0);
    checkOutput("t1Busy", busy, 0);
    checkOutput("t1PlayHeld", play, 1);

    $display("[TB] start and stop together while idle");
    src_addr = 24'h123456; sec_count = 16'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    checkOutput("ssBusy", busy, 0);
    checkOutput("ssPlayDropped", play, 0);

    $display("[TB] start with zero sectors");
    base = doneCnt; busySeen = 0; src = 24'(addrRstCnt);
    sec_count = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("zeroDone", doneCnt - base, 1);
    checkOutput("zeroBusy", busySeen, 0);
    checkOutput("zeroAddrRst", addrRstCnt, int'(src));

    $display("[TB] stop during a slow fetch");
    fixedLat = 5; curLat = 5;
    src = 24'($urandom);
    buildExp(src, 1, 1);
    applyStimulus(src, 16'd1, 1'b0);
    base = addrRstCnt;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stopReqHeld", mem_req, 1);
    checkOutput("stopStillBusy", busy, 1);
    repeat (12) @(negedge clk);
    checkOutput("stopNoWrite", writeCnt, 0);
    checkOutput("stopBusy", busy, 0);
    checkOutput("stopPlay", play, 0);
    checkOutput("stopAddrRst", addrRstCnt - base, 1);
    fixedLat = -1;
    expQ.delete();

    $display("[TB] random latency, space held off after sector 1");
    maxLat = 3; curLat = 1;
    src = 24'($urandom);
    buildExp(src, 2, 1);
    applyStimulus(src, 16'd2, 1'b0);
    waitWrites(200, 2000);
    src_addr = 24'h000000; sec_count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!play && n < 20000) begin
        @(negedge clk);
        n++;
      end
    end
    can_wr = 1'b0;
    checkOutput("t2PlayAfterSector1", writeCnt, SB);
    checkOutput("t2SecLeftMid", sec_left, 1);
    base = reqCnt;
    repeat (100) @(negedge clk);
    checkOutput("t2NoReqWhileFull", reqCnt - base, 0);
    checkOutput("t2NoWriteWhileFull", writeCnt, SB);
    can_wr = 1'b1;
    waitDone(25000);
    checkOutput("t2Writes", writeCnt, 2 * SB);
    checkOutput("t2QueueEmpty", expQ.size(), 0);
    checkOutput("t2SecLeft", sec_left, 0);

    $display("[TB] looping single sector");
    maxLat = 0; curLat = 0;
    base = doneCnt;
    buildExp(24'h001000, 1, 3);
    applyStimulus(24'h001000, 16'd1, 1'b1);
    waitWrites(2 * SB + 50, 15000);
    checkOutput("loopSecLeft", sec_left, 1);
    checkOutput("loopNoDone", doneCnt - base, 0);
    checkOutput("loopPlay", play, 1);
    src = 24'(addrRstCnt);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("loopStopBusy", busy, 0);
    checkOutput("loopStopPlay", play, 0);
    checkOutput("loopStopAddrRst", addrRstCnt - int'(src), 1);
    checkOutput("loopStopNoDone", doneCnt - base, 0);
    expQ.delete();

    $display("[TB] reset mid-sector, then restart across address wrap");
    maxLat = 2;
    buildExp(24'hFFFF00, 1, 1);
    applyStimulus(24'hFFFF00, 16'd1, 1'b0);
    waitWrites(500, 4000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("midReset");
    expQ.delete();
    @(negedge clk);
    src = 24'hFFF800 + 24'($urandom_range(255, 0));
    buildExp(src, 1, 1);
    applyStimulus(src, 16'd1, 1'b0);
    waitDone(12000);
    checkOutput("t6Writes", writeCnt, SB);
    checkOutput("t6QueueEmpty", expQ.size(), 0);
    checkOutput("t6PlayHeld", play, 1);
    checkOutput("t6Busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
